transmitter_sequencer: RTL and testbench
========================================

TRANSMITTER_SEQUENCER -- requirements
Module: transmitter_sequencer

Interface
REQ-001 SHALL have parameter SYS_LEN, default 16: systematic bits per frame, range 2..255.
REQ-002 SHALL have parameter PAR_LEN, default 16: parity bits per frame, range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level request to send one frame; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port tx_ready  input  1  downstream accepts the current bit this cycle.
REQ-008 SHALL have port s  output  1  transmitter_mux select: 1 = in1 (systematic), 0 = in2 (parity); registered.
REQ-009 SHALL have port tx_valid  output  1  mux output y carries a valid bit; registered.
REQ-010 SHALL have port sys_rd  output  1  advance systematic source; combinational = tx_valid & tx_ready & s.
REQ-011 SHALL have port par_rd  output  1  advance parity source; combinational = tx_valid & tx_ready & ~s.
REQ-012 SHALL have port bit_idx  output  8  index of the current bit within its segment; registered.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final parity bit transfers; registered.

Function
REQ-015 SHALL implement FSM states IDLE, SYS, PAR (plus GAP per REQ-027).
REQ-016 SHALL, in IDLE with start=1 and abort=0, enter SYS next cycle with s=1, tx_valid=1, bit_idx=0.
REQ-017 SHALL count a transfer only on cycles where tx_valid=1 and tx_ready=1; tx_ready=0 holds state, s and bit_idx unchanged (stall).
REQ-018 SHALL, in SYS, increment bit_idx per transfer; the transfer at bit_idx=SYS_LEN-1 enters PAR with s=0 and bit_idx=0, with no bubble cycle.
REQ-019 SHALL, in PAR, increment bit_idx per transfer; the transfer at bit_idx=PAR_LEN-1 enters IDLE (or GAP), with tx_valid=0, bit_idx=0 and done=1 for exactly one cycle.
REQ-020 SHALL give one frame exactly SYS_LEN sys_rd pulses followed by PAR_LEN par_rd pulses; minimum duration is SYS_LEN+PAR_LEN cycles.
REQ-021 SHALL ignore start while busy=1; no queuing.
REQ-022 SHALL support back-to-back frames: start=1 in the done cycle (IDLE) is accepted.
REQ-023 SHALL, on abort=1 in any state, go to IDLE next cycle with tx_valid=0, s=0, bit_idx=0 and no done pulse; abort has priority over start and over a concurrent final transfer.
REQ-024 SHALL keep s=0 and tx_valid=0 whenever in IDLE.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, s=0, tx_valid=0, bit_idx=0, done=0, busy=0, independent of clk; sys_rd=par_rd=0 follow.
REQ-026 SHALL, on reset mid-frame, discard the frame with no done pulse; operation resumes on the first start after release.

Configuration
REQ-027 SHALL compile in state GAP when macro TX_INTERFRAME_GAP_EN is defined: after the last parity transfer, spend one cycle in GAP (tx_valid=0, busy=1, done=1, start ignored), then enter IDLE; minimum frame period is SYS_LEN+PAR_LEN+2 cycles.
REQ-028 SHALL, without TX_INTERFRAME_GAP_EN, omit GAP and go directly from PAR to IDLE per REQ-019; minimum frame period is SYS_LEN+PAR_LEN+1 cycles.

Verification
REQ-029 SHALL cover a basic frame: defaults, tx_ready=1, start pulsed once -> 16 cycles s=1 with sys_rd=1, then 16 cycles s=0 with par_rd=1, done=1 in cycle 33 after the start was accepted.
REQ-030 SHALL cover stalls: tx_ready low on every odd cycle -> still exactly 16 sys_rd and 16 par_rd pulses; bit_idx and s hold during stalls; the frame takes 64 cycles.
REQ-031 SHALL cover back-to-back frames: start held high -> consecutive frames with a single tx_valid=0 cycle between them (two with TX_INTERFRAME_GAP_EN); start while busy adds no frame.
REQ-032 SHALL cover abort: abort at PAR bit_idx=5 -> IDLE next cycle, tx_valid=0, no done; abort together with the final transfer -> no done.
REQ-033 SHALL cover async reset: rst_n low at SYS bit_idx=7 between clock edges -> outputs at reset values immediately; the next start begins at bit_idx=0.
REQ-034 SHALL cover length corners: SYS_LEN=2, PAR_LEN=255 -> exactly 2 sys_rd and 255 par_rd pulses; bit_idx reaches 254 with no wrap.

Source files
------------

// File: rtl/transmitter_sequencer.sv
//==============================================================================
// Module      : transmitter_sequencer
// Description : Frame sequencer steering transmitter_mux through SYS_LEN
//               systematic bits then PAR_LEN parity bits, with handshake
//               stalls and abort. Optional macro TX_INTERFRAME_GAP_EN adds
//               a one-cycle GAP state after each completed frame.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module transmitter_sequencer #(
    parameter int SYS_LEN = 16,
    parameter int PAR_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       tx_ready,
    output logic       s,
    output logic       tx_valid,
    output logic       sys_rd,
    output logic       par_rd,
    output logic [7:0] bit_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_SYS_LAST = 8'(SYS_LEN - 1);
    localparam logic [7:0] c_PAR_LAST = 8'(PAR_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYS  = 2'd1,
        ST_PAR  = 2'd2
`ifdef TX_INTERFRAME_GAP_EN
        ,
        ST_GAP  = 2'd3
`endif
    } state_t;

    state_t     r_state;
    logic       r_s;
    logic       r_tx_valid;
    logic [7:0] r_bit_idx;
    logic       r_done;

    state_t     w_state_nxt;
    logic       w_s_nxt;
    logic       w_valid_nxt;
    logic [7:0] w_idx_nxt;
    logic       w_done_nxt;
    logic       w_xfer;

    assign w_xfer = r_tx_valid & tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s        <= 1'b0;
            r_tx_valid <= 1'b0;
            r_bit_idx  <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_tx_valid <= w_valid_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_valid_nxt = r_tx_valid;
        w_idx_nxt   = r_bit_idx;
        w_done_nxt  = 1'b0;

        // Abort wins over start and over a concurrent final parity transfer.
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_s_nxt     = 1'b0;
            w_valid_nxt = 1'b0;
            w_idx_nxt   = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_SYS;
                        w_s_nxt     = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = 8'd0;
                    end
                end
                ST_SYS: begin
                    if (w_xfer) begin
                        if (r_bit_idx == c_SYS_LAST) begin
                            w_state_nxt = ST_PAR;
                            w_s_nxt     = 1'b0;
                            w_idx_nxt   = 8'd0;
                        end else begin
                            w_idx_nxt = r_bit_idx + 8'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_xfer) begin
                        if (r_bit_idx == c_PAR_LAST) begin
`ifdef TX_INTERFRAME_GAP_EN
                            w_state_nxt = ST_GAP;
`else
                            w_state_nxt = ST_IDLE;
`endif
                            w_valid_nxt = 1'b0;
                            w_idx_nxt   = 8'd0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_bit_idx + 8'd1;
                        end
                    end
                end
`ifdef TX_INTERFRAME_GAP_EN
                ST_GAP: begin
                    w_state_nxt = ST_IDLE;
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_idx_nxt   = 8'd0;
                end
            endcase
        end
    end

    assign s        = r_s;
    assign tx_valid = r_tx_valid;
    assign bit_idx  = r_bit_idx;
    assign done     = r_done;
    assign busy     = (r_state != ST_IDLE);
    assign sys_rd   = r_tx_valid & tx_ready & r_s;
    assign par_rd   = r_tx_valid & tx_ready & ~r_s;

endmodule

`default_nettype wire

// File: tb/tb_transmitter_sequencer.sv
//==============================================================================
// Module      : tb_transmitter_sequencer
// Description : Scoreboard bench for transmitter_sequencer (default lengths)
//               plus a SYS_LEN=2 / PAR_LEN=255 corner instance.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_transmitter_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, tx_ready;
    logic       s, tx_valid, sys_rd, par_rd, busy, done;
    logic [7:0] bit_idx;

    logic       c_start, c_abort, c_ready;
    logic       c_s, c_valid, c_sys_rd, c_par_rd, c_busy, c_done;
    logic [7:0] c_idx;

    transmitter_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tx_ready(tx_ready),
        .s(s), .tx_valid(tx_valid), .sys_rd(sys_rd), .par_rd(par_rd),
        .bit_idx(bit_idx), .busy(busy), .done(done)
    );

    transmitter_sequencer #(.SYS_LEN(2), .PAR_LEN(255)) dut_corner (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .tx_ready(c_ready),
        .s(c_s), .tx_valid(c_valid), .sys_rd(c_sys_rd), .par_rd(c_par_rd),
        .bit_idx(c_idx), .busy(c_busy), .done(c_done)
    );

    localparam int DONE_CODE = 4096;

    int cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    int q[$];
    int n_sys = 0, n_par = 0;
    int c_nsys = 0, c_npar = 0, c_maxidx = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 1 = systematic bit (s=1, sys_rd), kind 0 = parity bit (par_rd)
    task automatic push_seg(input int kind, input int from, input int to);
        for (int i = from; i <= to; i++)
            q.push_back(kind == 1 ? (1024 + 256 + i) : (512 + i));
    endtask

    task automatic push_frame();
        push_seg(1, 0, 15);
        push_seg(0, 0, 15);
        q.push_back(DONE_CODE);
    endtask

    // Monitor: pops the scoreboard on every transfer and done pulse.
    initial begin
        logic prev_stall;
        int   prev_si, act, exp;
        prev_stall = 1'b0;
        prev_si = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", int'({s, tx_valid, bit_idx}), prev_si);
                prev_stall = tx_valid && !tx_ready;
                prev_si    = int'({s, tx_valid, bit_idx});
                if (sys_rd || par_rd) begin
                    n_sys += int'(sys_rd);
                    n_par += int'(par_rd);
                    act = (s ? 1024 : 0) + (sys_rd ? 256 : 0) + (par_rd ? 512 : 0) + int'(bit_idx);
                    exp = (q.size() > 0) ? q.pop_front() : -1;
                    check("sb_xfer", act, exp);
                end
                if (done) begin
                    act = DONE_CODE + int'(tx_valid);
                    exp = (q.size() > 0) ? q.pop_front() : -1;
                    check("sb_done", act, exp);
                end
                c_nsys += int'(c_sys_rd);
                c_npar += int'(c_par_rd);
                if (c_valid && int'(c_idx) > c_maxidx) c_maxidx = int'(c_idx);
            end
        end
    end

    // Issues one start pulse and returns cycles from acceptance to done.
    task automatic run_frame(input int stall, input int limit, output int delta);
        int c0;
        step(); start = 1'b1; tx_ready = 1'b1;
        step(); start = 1'b0; c0 = cyc;
        check("accept_state", int'({s, tx_valid, busy, bit_idx}), int'({3'b111, 8'd0}));
        delta = -1;
        for (int i = 0; i < limit; i++) begin
            tx_ready = (stall != 0) ? (i % 2 == 1) : 1'b1;
            step();
            if (done) begin
                delta = cyc - c0;
                break;
            end
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, guard;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
        c_start = 1'b0; c_abort = 1'b0; c_ready = 1'b1;
        #2;
        check("reset_outs", int'({s, tx_valid, busy, done, sys_rd, par_rd, bit_idx}), 0);
        check("reset_corner", int'({c_s, c_valid, c_busy, c_done, c_idx}), 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic frame
        n_sys = 0; n_par = 0;
        push_frame();
        run_frame(0, 100, d);
        check("basic_len", d, 32);
        check("basic_cnt", n_sys * 1000 + n_par, 16016);
        step();
        check("done_one_cycle", int'(done), 0);
        check("basic_sb_empty", q.size(), 0);

        // Stalls on every odd cycle
        n_sys = 0; n_par = 0;
        push_frame();
        run_frame(1, 200, d);
        check("stall_len", d, 64);
        check("stall_cnt", n_sys * 1000 + n_par, 16016);
        step();

        // Back-to-back with start held
        push_frame(); push_frame();
        start = 1'b1;
        step();
        guard = 0;
        while (!done && guard < 100) begin step(); guard++; end
        check("b2b_done_valid", int'({done, tx_valid}), 2);
        step();
`ifdef TX_INTERFRAME_GAP_EN
        check("b2b_gap_idle", int'({tx_valid, busy}), 0);
        step();
`endif
        check("b2b_restart", int'({done, s, tx_valid, bit_idx}), int'({2'b01, 1'b1, 8'd0}));
        repeat (3) step();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin step(); guard++; end
        check("b2b_done2", int'(done), 1);
        repeat (5) step();
        check("b2b_no_extra", int'({busy, tx_valid}), 0);
        check("b2b_sb_empty", q.size(), 0);

        // Abort at parity bit 5
        push_seg(1, 0, 15); push_seg(0, 0, 5);
        step(); start = 1'b1;
        step(); start = 1'b0;
        guard = 0;
        while (!(tx_valid && !s && bit_idx == 8'd5) && guard < 100) begin step(); guard++; end
        abort = 1'b1;
        step(); abort = 1'b0;
        check("abort_mid", int'({tx_valid, s, busy, done, bit_idx}), 0);
        step();
        check("abort_mid_nodone", int'(done), 0);
        check("abort_mid_sb", q.size(), 0);

        // Abort together with the final parity transfer
        push_seg(1, 0, 15); push_seg(0, 0, 15);
        step(); start = 1'b1;
        step(); start = 1'b0;
        guard = 0;
        while (!(tx_valid && !s && bit_idx == 8'd15) && guard < 100) begin step(); guard++; end
        abort = 1'b1;
        step(); abort = 1'b0;
        check("abort_final", int'({tx_valid, busy, done}), 0);
        step();
        check("abort_final_nodone", int'(done), 0);
        check("abort_final_sb", q.size(), 0);

        // Abort has priority over start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort_over_start", int'({busy, tx_valid}), 0);

        // Asynchronous reset at systematic bit 7
        push_seg(1, 0, 6);
        step(); start = 1'b1;
        step(); start = 1'b0;
        guard = 0;
        while (!(tx_valid && s && bit_idx == 8'd7) && guard < 100) begin step(); guard++; end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", int'({s, tx_valid, busy, done, sys_rd, par_rd, bit_idx}), 0);
        check("async_rst_sb", q.size(), 0);
        step(); rst_n = 1'b1;
        step();
        push_frame();
        run_frame(0, 100, d);
        check("post_rst_len", d, 32);
        step();

        // Length corners on the second instance
        c_nsys = 0; c_npar = 0; c_maxidx = 0;
        step(); c_start = 1'b1;
        step(); c_start = 1'b0;
        d = -1;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (c_done) begin d = i; break; end
        end
        check("corner_len", d, 257);
        check("corner_sys_cnt", c_nsys, 2);
        check("corner_par_cnt", c_npar, 255);
        check("corner_max_idx", c_maxidx, 254);
        step();
        check("corner_idle", int'({c_busy, c_valid, c_idx}), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
